approx_mul_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8x8 quadrant-split approximate multiplier.
- Splits unsigned WIDTH-bit operands into high/low halves and forms four half-width partial products (HH, HL, LH, LL).
- Each quadrant can run exact or approximate (truncated), selected per transaction by a runtime mode mask.
- Quadrants are recombined by a shift-add with a valid/ready handshake on both sides. The block sits between an operand source and a result consumer in the accuracy-exploration datapath.

---
 rtl/approx_mul_pipe.sv | 106 ++++++++++
 tb/tb_approx_mul_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_pipe.sv
// Three-stage elastic quadrant-split multiplier with per-quadrant truncation.
// Operands split into H-bit halves; four partial products are recombined exactly.
module approx_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic [3:0]         out_mode,
  output logic [CNT_W-1:0]   op_count
);

  localparam int H  = WIDTH / 2;
  localparam int QW = 2 * H;
  localparam int PW = 2 * WIDTH;

  // Exact H x H product, with the low APPROX_BITS cleared when approximate.
  // Bits beyond the product width saturate the clear to the whole product.
  function automatic logic [QW-1:0] quad_mul(input logic [H-1:0] x,
                                             input logic [H-1:0] y,
                                             input logic approx);
    logic [QW-1:0] q;
    q = {{H{1'b0}}, x} * {{H{1'b0}}, y};
    if (approx) begin
      for (int i = 0; i < QW; i++) begin
        if (i < APPROX_BITS) q[i] = 1'b0;
      end
    end
    return q;
  endfunction

  // The exact sum never exceeds (2^WIDTH-1)^2, so PW bits hold it with no carry-out.
  function automatic logic [PW-1:0] recombine(input logic [QW-1:0] ll,
                                               input logic [QW-1:0] lh,
                                               input logic [QW-1:0] hl,
                                               input logic [QW-1:0] hh);
    logic [PW-1:0] s;
    s = PW'(ll) + ((PW'(lh) + PW'(hl)) << H) + (PW'(hh) << WIDTH);
    return s;
  endfunction

  logic             vld_p0, vld_p1, vld_p2;
  logic             adv_p0, adv_p1, adv_p2;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [3:0]       mode_p0, mode_p1, mode_p2;
  logic [QW-1:0]    ll_p1, lh_p1, hl_p1, hh_p1;
  logic [PW-1:0]    prod_p2;

  // An empty stage always loads, so bubbles collapse under backpressure.
  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign adv_p0   = !vld_p0 || adv_p1;
  assign in_ready = adv_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      prod_p2  <= '0;
      mode_p2  <= '0;
      op_count <= '0;
    end else begin
      if (adv_p0) vld_p0 <= in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
      // S2 -> S3: shift-add recombination
      if (adv_p2 && vld_p1) begin
        prod_p2 <= recombine(ll_p1, lh_p1, hl_p1, hh_p1);
        mode_p2 <= mode_p1;
      end
      if (vld_p2 && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // input -> S1: operand capture on accept
    if (adv_p0 && in_valid) begin
      a_p0    <= a;
      b_p0    <= b;
      mode_p0 <= mode;
    end
    // S1 -> S2: quadrant products
    if (adv_p1 && vld_p0) begin
      ll_p1   <= quad_mul(a_p0[H-1:0],     b_p0[H-1:0],     mode_p0[0]);
      lh_p1   <= quad_mul(a_p0[H-1:0],     b_p0[WIDTH-1:H], mode_p0[1]);
      hl_p1   <= quad_mul(a_p0[WIDTH-1:H], b_p0[H-1:0],     mode_p0[2]);
      hh_p1   <= quad_mul(a_p0[WIDTH-1:H], b_p0[WIDTH-1:H], mode_p0[3]);
      mode_p1 <= mode_p0;
    end
  end

  assign out_valid = vld_p2;
  assign prod      = prod_p2;
  assign out_mode  = mode_p2;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed and randomised checks of approx_mul_pipe across three parameter sets.
module tb_approx_mul_pipe;

  logic clk;
  logic rst_n;
  int   n_pass, n_fail, n_total;

  // dut0: WIDTH=8, APPROX_BITS=2, CNT_W=16 (directed)
  logic        iv0, ir0, ov0, or0;
  logic [7:0]  a0, b0;
  logic [3:0]  m0, om0;
  logic [15:0] p0, cnt0;

  // dut1: WIDTH=12, APPROX_BITS=3, CNT_W=4 ; dut2: WIDTH=8, APPROX_BITS=0, CNT_W=4
  logic        iv_s, or_s;
  logic [3:0]  m_s;
  logic        ir1, ov1, ir2, ov2;
  logic [11:0] a1, b1;
  logic [7:0]  a2, b2;
  logic [23:0] p1;
  logic [15:0] p2;
  logic [3:0]  om1, om2, cnt1, cnt2;

  approx_mul_pipe #(.WIDTH(8), .APPROX_BITS(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .mode(m0), .out_valid(ov0), .out_ready(or0), .prod(p0), .out_mode(om0),
    .op_count(cnt0));

  approx_mul_pipe #(.WIDTH(12), .APPROX_BITS(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir1), .a(a1), .b(b1),
    .mode(m_s), .out_valid(ov1), .out_ready(or_s), .prod(p1), .out_mode(om1),
    .op_count(cnt1));

  approx_mul_pipe #(.WIDTH(8), .APPROX_BITS(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir2), .a(a2), .b(b2),
    .mode(m_s), .out_valid(ov2), .out_ready(or_s), .prod(p2), .out_mode(om2),
    .op_count(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference: quadrant products, truncation as shift-down/shift-up, weighted sum.
  function automatic longint model(input int w, input int ab, input longint x,
                                   input longint y, input logic [3:0] m);
    int     h;
    longint msk;
    longint q[4];
    h   = w / 2;
    msk = (longint'(1) << h) - 1;
    q[0] = (x & msk) * (y & msk);
    q[1] = (x & msk) * (y >> h);
    q[2] = (x >> h) * (y & msk);
    q[3] = (x >> h) * (y >> h);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) q[k] = (ab >= 2 * h) ? 0 : ((q[k] >> ab) << ab);
    end
    return q[0] + ((q[1] + q[2]) << h) + (q[3] << w);
  endfunction

  // Present one beat on dut0 with out_ready high and check its 3-cycle latency.
  task automatic one_beat(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] m, input logic [15:0] exp);
    chk({tag, "_in_ready"}, 64'(ir0), 64'(1));
    iv0 = 1'b1; a0 = x; b0 = y; m0 = m;
    tick();
    iv0 = 1'b0;
    tick();
    chk({tag, "_early"}, 64'(ov0), 64'(0));
    tick();
    chk({tag, "_valid"}, 64'(ov0), 64'(1));
    chk({tag, "_prod"}, 64'(p0), 64'(exp));
    chk({tag, "_mode"}, 64'(om0), 64'(m));
    tick();
    chk({tag, "_drain"}, 64'(ov0), 64'(0));
  endtask

  localparam int N = 24;

  initial begin
    int acc, got, nxt;
    int sent1, sent2, got1, got2;
    logic [27:0] exp1[$];
    logic [15:0] exp2[$];
    logic [27:0] e1;
    logic [15:0] e2;

    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0;
    iv0 = 0; a0 = 0; b0 = 0; m0 = 0; or0 = 1;
    iv_s = 0; or_s = 0; m_s = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 64'(ov0), 64'(0));
    chk("rst_prod", 64'(p0), 64'(0));
    chk("rst_out_mode", 64'(om0), 64'(0));
    chk("rst_op_count", 64'(cnt0), 64'(0));
    rst_n = 1'b1;
    tick();

    // Directed single beats
    one_beat("ff_exact", 8'hFF, 8'hFF, 4'h0, 16'hFE01);
    one_beat("ff_all_apx", 8'hFF, 8'hFF, 4'hF, 16'hFCE0);
    one_beat("ff_ll_apx", 8'hFF, 8'hFF, 4'h1, 16'hFE00);
    one_beat("hh_trunc", 8'h10, 8'h10, 4'hF, 16'h0000);
    one_beat("hh_exact", 8'h10, 8'h10, 4'h7, 16'h0100);
    chk("count_after_directed", 64'(cnt0), 64'(5));

    // Backpressure: out_ready low for 6 cycles with in_valid held high
    pulse_reset();
    or0 = 1'b0; iv0 = 1'b1; a0 = 8'd1; b0 = 8'd3; m0 = 4'h0;
    acc = 0; got = 0; nxt = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (iv0 && ir0) begin acc++; nxt++; end
      tick();
      a0 = 8'(nxt);
    end
    chk("bp_accepted", 64'(acc), 64'(3));
    chk("bp_in_ready_low", 64'(ir0), 64'(0));
    chk("bp_hold_valid", 64'(ov0), 64'(1));
    chk("bp_hold_prod", 64'(p0), 64'(3));
    or0 = 1'b1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      if (iv0 && ir0) nxt++;
      if (ov0) begin
        chk("bp_out", 64'(p0), 64'(3 * (got + 1)));
        got++;
      end
      tick();
      a0  = 8'(nxt);
      iv0 = (nxt <= 10);
    end
    chk("bp_all_out", 64'(got), 64'(10));
    chk("bp_op_count", 64'(cnt0), 64'(10));
    tick();
    chk("bp_empty", 64'(ov0), 64'(0));

    // Reset with two beats in flight
    iv0 = 1'b1; a0 = 8'd5; b0 = 8'd5; m0 = 4'h0;
    tick();
    a0 = 8'd6; b0 = 8'd6;
    tick();
    iv0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov0), 64'(0));
    chk("midrst_op_count", 64'(cnt0), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("midrst_no_stale", 64'(ov0), 64'(0));
    end
    one_beat("after_rst", 8'd7, 8'd9, 4'h0, 16'd63);

    // Random sweep on dut1/dut2 with random out_ready
    sent1 = 0; sent2 = 0; got1 = 0; got2 = 0;
    for (int c = 0; c < 2000 && (got1 < N || got2 < N); c++) begin
      iv_s = (sent1 < N) && ($urandom_range(0, 3) != 0);
      or_s = $urandom_range(0, 1) == 1;
      a1 = 12'($urandom); b1 = 12'($urandom);
      a2 = 8'($urandom);  b2 = 8'($urandom);
      m_s = 4'($urandom);
      @(negedge clk);
      if (iv_s && ir1) begin
        exp1.push_back({m_s, 24'(model(12, 3, longint'(a1), longint'(b1), m_s))});
        sent1++;
      end
      if (iv_s && ir2) begin
        exp2.push_back({8'h00, a2} * {8'h00, b2});
        sent2++;
      end
      if (ov1 && or_s) begin
        if (exp1.size() == 0) chk("sw12_extra", 64'(1), 64'(0));
        else begin
          e1 = exp1.pop_front();
          chk("sw12_prod_mode", 64'({om1, p1}), 64'(e1));
        end
        got1++;
      end
      if (ov2 && or_s) begin
        if (exp2.size() == 0) chk("sw8_extra", 64'(1), 64'(0));
        else begin
          e2 = exp2.pop_front();
          chk("sw8_exact_prod", 64'(p2), 64'(e2));
        end
        got2++;
      end
      tick();
    end
    chk("sw12_count", 64'(got1), 64'(N));
    chk("sw8_count", 64'(got2), 64'(N));
    chk("sw12_op_count_wrap", 64'(cnt1), 64'(N % 16));
    chk("sw8_op_count_wrap", 64'(cnt2), 64'(N % 16));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
